// File: rtl/rs_select.sv
// Reservation station feeding the issue stage: buffers decoded instructions,
// wakes sources on CDB tag broadcasts, and selects the lowest-index ready
// entry into the ID/IS pipeline register each cycle.

`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 5
`endif

package rs_select_pkg;

   typedef struct packed {
      logic [`PHYS_REG_IDX_SZ:0] reg_num;
   } REG_IDX;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      REG_IDX      src1_reg;
      REG_IDX      src2_reg;
      REG_IDX      dest_reg;
   } ID_IS_PACKET;

endpackage

module rs_select
   import rs_select_pkg::*;
#(
   parameter int RS_SZ     = 8,
   parameter int RS_IDX_SZ = $clog2(RS_SZ)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      dispatch_valid,
   input  ID_IS_PACKET               dispatch_packet,
   input  logic                      dispatch_src1_ready,
   input  logic                      dispatch_src2_ready,
   input  logic                      cdb_valid,
   input  logic [`PHYS_REG_IDX_SZ:0] cdb_tag,
   input  logic                      issue_stall,
   input  logic                      squash,
   output logic                      dispatch_ready,
   output logic [RS_IDX_SZ:0]        free_count,
   output ID_IS_PACKET               id_is_reg
);

   localparam logic [RS_IDX_SZ:0] RS_SZ_W = (RS_IDX_SZ + 1)'(RS_SZ);

   logic [RS_SZ-1:0] entry_valid;
   logic [RS_SZ-1:0] src1_rdy;
   logic [RS_SZ-1:0] src2_rdy;
   ID_IS_PACKET      entry_pkt [RS_SZ];

   logic [RS_IDX_SZ:0]   n_valid;
   logic                 free_found;
   logic [RS_IDX_SZ-1:0] free_idx;
   logic                 sel_found;
   logic [RS_IDX_SZ-1:0] sel_idx;
   logic                 dispatch_fire;
   logic                 issue_fire;
   logic                 disp_src1_hit;
   logic                 disp_src2_hit;

   // Occupancy count from registered state; entries freed this cycle are not anticipated.
   always_comb begin
      n_valid = '0;
      for (int i = 0; i < RS_SZ; i++) begin
         n_valid = n_valid + {{RS_IDX_SZ{1'b0}}, entry_valid[i]};
      end
   end

   assign free_count     = RS_SZ_W - n_valid;
   assign dispatch_ready = (free_count != '0);

   // Lowest-index free slot and lowest-index ready candidate (descending scan, last hit wins).
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      sel_found  = 1'b0;
      sel_idx    = '0;
      for (int i = RS_SZ - 1; i >= 0; i--) begin
         if (!entry_valid[i]) begin
            free_found = 1'b1;
            free_idx   = RS_IDX_SZ'(i);
         end
         if (entry_valid[i] && src1_rdy[i] && src2_rdy[i]) begin
            sel_found = 1'b1;
            sel_idx   = RS_IDX_SZ'(i);
         end
      end
   end

   // The dispatching instruction also snoops the CDB so a same-cycle broadcast isn't lost.
   always_comb begin
      dispatch_fire = dispatch_valid && dispatch_ready && free_found && !squash;
      issue_fire    = sel_found && !issue_stall && !squash;
      disp_src1_hit = cdb_valid && (dispatch_packet.src1_reg.reg_num == cdb_tag);
      disp_src2_hit = cdb_valid && (dispatch_packet.src2_reg.reg_num == cdb_tag);
   end

   // Entry storage: squash flush, CDB wakeup, free on issue, write on dispatch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         entry_valid <= '0;
         src1_rdy    <= '0;
         src2_rdy    <= '0;
         for (int i = 0; i < RS_SZ; i++) begin
            entry_pkt[i] <= '0;
         end
      end else if (squash) begin
         entry_valid <= '0;
      end else begin
         for (int i = 0; i < RS_SZ; i++) begin
            if (cdb_valid && entry_valid[i]) begin
               if (entry_pkt[i].src1_reg.reg_num == cdb_tag) src1_rdy[i] <= 1'b1;
               if (entry_pkt[i].src2_reg.reg_num == cdb_tag) src2_rdy[i] <= 1'b1;
            end
         end
         if (issue_fire) begin
            entry_valid[sel_idx] <= 1'b0;
         end
         if (dispatch_fire) begin
            entry_valid[free_idx] <= 1'b1;
            entry_pkt[free_idx]   <= dispatch_packet;
            src1_rdy[free_idx]    <= dispatch_src1_ready | disp_src1_hit;
            src2_rdy[free_idx]    <= dispatch_src2_ready | disp_src2_hit;
         end
      end
   end

   // ID/IS pipeline register: squash clears valid, stall holds, otherwise load the winner.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         id_is_reg <= '0;
      end else if (squash) begin
         id_is_reg.valid <= 1'b0;
      end else if (!issue_stall) begin
         if (sel_found) begin
            id_is_reg       <= entry_pkt[sel_idx];
            id_is_reg.valid <= 1'b1;
         end else begin
            id_is_reg.valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rs_select.sv
// Directed bench for rs_select: a slot-level reference model predicts the
// outputs every cycle, and literal expectations pin the scenarios.

module tb_rs_select;
   import rs_select_pkg::*;

   localparam int N = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        dispatch_valid;
   ID_IS_PACKET dispatch_packet;
   logic        dispatch_src1_ready;
   logic        dispatch_src2_ready;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic        issue_stall;
   logic        squash;
   logic        dispatch_ready;
   logic [3:0]  free_count;
   ID_IS_PACKET id_is_reg;

   int n_checks = 0;
   int n_fail   = 0;
   bit started  = 1'b0;

   rs_select #(.RS_SZ(N)) dut (
      .clock               (clock),
      .reset               (reset),
      .dispatch_valid      (dispatch_valid),
      .dispatch_packet     (dispatch_packet),
      .dispatch_src1_ready (dispatch_src1_ready),
      .dispatch_src2_ready (dispatch_src2_ready),
      .cdb_valid           (cdb_valid),
      .cdb_tag             (cdb_tag),
      .issue_stall         (issue_stall),
      .squash              (squash),
      .dispatch_ready      (dispatch_ready),
      .free_count          (free_count),
      .id_is_reg           (id_is_reg)
   );

   always #5 clock = ~clock;

   // Reference model: slots hold {packet, ready flags}; applies the rules per edge.
   bit          m_used [N];
   ID_IS_PACKET m_pkt  [N];
   bit          m_r1   [N];
   bit          m_r2   [N];
   ID_IS_PACKET m_out;

   function automatic int m_count();
      int c = 0;
      foreach (m_used[i]) if (m_used[i]) c++;
      return c;
   endfunction

   always @(posedge clock or posedge reset) begin
      int pick, slot;
      if (reset) begin
         foreach (m_used[i]) begin
            m_used[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_pkt[i] = '0;
         end
         m_out = '0;
      end else if (squash) begin
         foreach (m_used[i]) m_used[i] = 0;
         m_out.valid = 1'b0;
      end else begin
         pick = -1;
         slot = -1;
         for (int i = N - 1; i >= 0; i--) begin
            if (m_used[i] && m_r1[i] && m_r2[i]) pick = i;
            if (!m_used[i]) slot = i;
         end
         if (!issue_stall) begin
            if (pick >= 0) begin
               m_out = m_pkt[pick];
               m_out.valid = 1'b1;
               m_used[pick] = 0;
            end else begin
               m_out.valid = 1'b0;
            end
         end
         if (cdb_valid) begin
            foreach (m_used[i]) begin
               if (m_used[i] && m_pkt[i].src1_reg.reg_num == cdb_tag) m_r1[i] = 1;
               if (m_used[i] && m_pkt[i].src2_reg.reg_num == cdb_tag) m_r2[i] = 1;
            end
         end
         // slot was chosen from the pre-edge occupancy, so a just-freed slot is not reused
         if (dispatch_valid && slot >= 0) begin
            m_used[slot] = 1;
            m_pkt[slot]  = dispatch_packet;
            m_r1[slot]   = dispatch_src1_ready || (cdb_valid && dispatch_packet.src1_reg.reg_num == cdb_tag);
            m_r2[slot]   = dispatch_src2_ready || (cdb_valid && dispatch_packet.src2_reg.reg_num == cdb_tag);
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (started && !reset) begin
         n_checks++;
         if (free_count !== 4'(N - m_count())) begin
            n_fail++;
            $display("FAIL model_free_count t=%0t got %0d expected %0d", $time, free_count, N - m_count());
         end
         n_checks++;
         if (dispatch_ready !== (m_count() < N)) begin
            n_fail++;
            $display("FAIL model_dispatch_ready t=%0t got %0b expected %0b", $time, dispatch_ready, m_count() < N);
         end
         n_checks++;
         if (id_is_reg.valid !== m_out.valid) begin
            n_fail++;
            $display("FAIL model_out_valid t=%0t got %0b expected %0b", $time, id_is_reg.valid, m_out.valid);
         end else if (m_out.valid && id_is_reg !== m_out) begin
            n_fail++;
            $display("FAIL model_out_packet t=%0t got %h expected %h", $time, id_is_reg, m_out);
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic disp(input logic [31:0] pc, input logic [5:0] t1, input logic r1,
                       input logic [5:0] t2, input logic r2);
      dispatch_valid              = 1'b1;
      dispatch_packet             = '0;
      dispatch_packet.valid       = 1'b1;
      dispatch_packet.pc          = pc;
      dispatch_packet.inst        = 32'hA000_0000 | pc;
      dispatch_packet.src1_reg.reg_num = t1;
      dispatch_packet.src2_reg.reg_num = t2;
      dispatch_packet.dest_reg.reg_num = pc[5:0];
      dispatch_src1_ready         = r1;
      dispatch_src2_ready         = r2;
   endtask

   task automatic cdb(input logic [5:0] tag);
      cdb_valid = 1'b1;
      cdb_tag   = tag;
   endtask

   initial begin
      reset = 1'b1;
      dispatch_valid = 1'b0; dispatch_packet = '0;
      dispatch_src1_ready = 1'b0; dispatch_src2_ready = 1'b0;
      cdb_valid = 1'b0; cdb_tag = '0; issue_stall = 1'b0; squash = 1'b0;
      #12;
      reset = 1'b0;
      started = 1'b1;
      chk("reset_free_count", free_count, 8);
      chk("reset_dispatch_ready", dispatch_ready, 1);
      chk("reset_out_valid", id_is_reg.valid, 0);

      // Ready-at-dispatch instruction issues one edge after it is written.
      disp(32'h100, 6'd0, 1, 6'd0, 1);
      cyc();
      dispatch_valid = 1'b0;
      chk("t1_after_dispatch_fc", free_count, 7);
      chk("t1_not_yet_valid", id_is_reg.valid, 0);
      cyc();
      chk("t1_issue_valid", id_is_reg.valid, 1);
      chk("t1_issue_pc", id_is_reg.pc, 32'h100);
      chk("t1_fc_back", free_count, 8);

      // Woken by CDB: eligible only on the edge after the wakeup edge.
      disp(32'h200, 6'd5, 0, 6'd0, 1);
      cyc();
      dispatch_valid = 1'b0;
      cyc(); cyc();
      chk("t2_waiting", id_is_reg.valid, 0);
      cdb(6'd5);
      cyc();
      cdb_valid = 1'b0;
      chk("t2_not_on_wake_edge", id_is_reg.valid, 0);
      cyc();
      chk("t2_issue_valid", id_is_reg.valid, 1);
      chk("t2_issue_pc", id_is_reg.pc, 32'h200);

      // Same-cycle dispatch and broadcast: stored ready.
      disp(32'h300, 6'd0, 1, 6'd9, 0);
      cdb(6'd9);
      cyc();
      dispatch_valid = 1'b0; cdb_valid = 1'b0;
      chk("t3_fc", free_count, 7);
      cyc();
      chk("t3_issue_pc", id_is_reg.pc, 32'h300);
      chk("t3_issue_valid", id_is_reg.valid, 1);
      cyc();

      // Fill to capacity, refuse the ninth, wake entry 2, refill into slot 2.
      for (int i = 0; i < N; i++) begin
         disp(32'h400 + 32'(4 * i), 6'(10 + i), 0, 6'd0, 1);
         cyc();
      end
      chk("t4_full_fc", free_count, 0);
      chk("t4_full_dr", dispatch_ready, 0);
      disp(32'h500, 6'd30, 0, 6'd0, 1);
      cyc();
      chk("t4_ninth_ignored", free_count, 0);
      cdb(6'd12);
      cyc();
      cdb_valid = 1'b0;
      chk("t4_wake_edge_fc", free_count, 0);
      cyc();
      chk("t4_issue_pc", id_is_reg.pc, 32'h408);
      chk("t4_fc_one", free_count, 1);
      cyc();
      dispatch_valid = 1'b0;
      chk("t4_refill_fc", free_count, 0);
      issue_stall = 1'b1;
      cdb(6'd13);
      cyc();
      cdb(6'd30);
      cyc();
      cdb_valid = 1'b0;
      issue_stall = 1'b0;
      cyc();
      chk("t4_slot2_first", id_is_reg.pc, 32'h500);
      cyc();
      chk("t4_slot3_next", id_is_reg.pc, 32'h40C);
      squash = 1'b1;
      cyc();
      squash = 1'b0;
      chk("t4_squash_fc", free_count, 8);

      // Ready entries at 1, 4, 6 held behind a stall, then issued in index order.
      disp(32'h5F0, 6'd0, 1, 6'd0, 1);
      cyc();
      disp(32'h601, 6'd0, 1, 6'd0, 1);
      cyc();
      chk("t5_before_stall", id_is_reg.pc, 32'h5F0);
      issue_stall = 1'b1;
      disp(32'h610, 6'd50, 0, 6'd0, 1); cyc();
      disp(32'h612, 6'd51, 0, 6'd0, 1); cyc();
      disp(32'h613, 6'd52, 0, 6'd0, 1); cyc();
      disp(32'h604, 6'd0, 1, 6'd0, 1);  cyc();
      disp(32'h615, 6'd53, 0, 6'd0, 1); cyc();
      disp(32'h606, 6'd0, 1, 6'd0, 1);  cyc();
      dispatch_valid = 1'b0;
      cyc(); cyc();
      chk("t5_held_pc", id_is_reg.pc, 32'h5F0);
      chk("t5_held_valid", id_is_reg.valid, 1);
      issue_stall = 1'b0;
      cyc();
      chk("t5_issue_1", id_is_reg.pc, 32'h601);
      cyc();
      chk("t5_issue_4", id_is_reg.pc, 32'h604);
      cyc();
      chk("t5_issue_6", id_is_reg.pc, 32'h606);
      cyc();
      chk("t5_drained", id_is_reg.valid, 0);
      chk("t5_fc", free_count, 4);

      // Squash with a same-cycle dispatch, then an asynchronous reset pulse.
      disp(32'h620, 6'd54, 0, 6'd0, 1);
      cyc();
      chk("t6_five_valid", free_count, 3);
      disp(32'h6FF, 6'd0, 1, 6'd0, 1);
      squash = 1'b1;
      cyc();
      squash = 1'b0;
      dispatch_valid = 1'b0;
      chk("t6_squash_fc", free_count, 8);
      chk("t6_squash_valid", id_is_reg.valid, 0);
      cyc();
      chk("t6_discarded_dispatch", id_is_reg.valid, 0);
      disp(32'h700, 6'd0, 1, 6'd0, 1);
      cyc();
      disp(32'h704, 6'd55, 0, 6'd0, 1);
      cyc();
      dispatch_valid = 1'b0;
      chk("t6_pre_reset_pc", id_is_reg.pc, 32'h700);
      chk("t6_pre_reset_fc", free_count, 7);
      #1 reset = 1'b1;
      #1;
      chk("t6_async_out", id_is_reg, 0);
      chk("t6_async_fc", free_count, 8);
      chk("t6_async_dr", dispatch_ready, 1);
      #1 reset = 1'b0;
      cyc();
      chk("t6_after_reset_valid", id_is_reg.valid, 0);
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
